// File: rtl/jacobi_eigval_sorter.sv
// Diagonal extractor for the Jacobi core output stream.
// Insertion-sorts eigenvalues on arrival and emits them largest first.
module jacobi_eigval_sorter #(
  parameter int N     = 8,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_dat_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  output logic [WIDTH-1:0] out_dat_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             out_vld_o,
  input  logic             out_rdy_i
);

  localparam int KW = $clog2(N + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] row, col, rp;
  logic [KW-1:0]    k;

  logic signed [WIDTH-1:0] val    [N];
  logic signed [WIDTH-1:0] val_sh [N];
  logic [IDX_W-1:0]        idx    [N];
  logic [IDX_W-1:0]        idx_sh [N];

  logic [N-1:0] ge, at_p;
  logic in_xfer, diag, last_in;
  logic out_hs, last_out;

  assign in_xfer  = in_vld_i && (state == COLLECT);
  assign diag     = in_xfer && (row == col);
  assign last_in  = diag && (row == LAST);
  assign out_hs   = (state == EMIT) && out_rdy_i;
  assign last_out = out_hs && (rp == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == COLLECT: if (last_in)  state_nx = EMIT;
      state == EMIT:    if (last_out) state_nx = COLLECT;
      default:          state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      rp  <= '0;
      k   <= '0;
    end else begin
      if (in_xfer) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (last_in)     rp <= '0;
      else if (out_hs) rp <= last_out ? '0 : rp + 1'b1;
      if (last_out)  k <= '0;
      else if (diag) k <= k + 1'b1;
    end
  end

  // Array stays sorted, so ge[] is a prefix mask and p is its first zero.
  always_comb begin
    for (int j = 0; j < N; j++)
      ge[j] = (KW'(j) < k) && (val[j] >= $signed(in_dat_i));
    at_p[0] = ~ge[0];
    for (int j = 1; j < N; j++)
      at_p[j] = ge[j-1] & ~ge[j];
    val_sh[0] = $signed(in_dat_i);
    idx_sh[0] = row;
    for (int j = 1; j < N; j++) begin
      val_sh[j] = val[j-1];
      idx_sh[j] = idx[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (diag) begin
      for (int j = 0; j < N; j++) begin
        if (!ge[j] && (KW'(j) <= k)) begin
          val[j] <= at_p[j] ? $signed(in_dat_i) : val_sh[j];
          idx[j] <= at_p[j] ? row : idx_sh[j];
        end
      end
    end
  end

  always_comb begin
    in_rdy_o   = rst || (state == COLLECT);
    out_vld_o  = !rst && (state == EMIT);
    out_dat_o  = '0;
    out_idx_o  = '0;
    out_last_o = 1'b0;
    if (out_vld_o) begin
      out_dat_o  = val[rp];
      out_idx_o  = idx[rp];
      out_last_o = (rp == LAST);
    end
  end

endmodule

// File: tb/tb_jacobi_eigval_sorter.sv
// Directed bench for jacobi_eigval_sorter at N=4.
// Hand-computed sort results, backpressure, bubbles, resets, back-to-back.
module tb_jacobi_eigval_sorter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_dat;
  logic          in_vld;
  logic          in_rdy;
  logic [W-1:0]  out_dat;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_vld;
  logic          out_rdy;

  int checks = 0;
  int errors = 0;

  jacobi_eigval_sorter #(.N(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_dat_i   (in_dat),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .out_dat_o  (out_dat),
    .out_idx_o  (out_idx),
    .out_last_o (out_last),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d [N], input bit bub);
    for (int e = 0; e < N * N; e++) begin
      in_vld = 1'b1;
      in_dat = (e / N == e % N) ? d[e / N] : 32'h7FFF_FFFF;
      chk("in_rdy_collect", in_rdy, 1);
      chk("no_vld_collect", out_vld, 0);
      step();
      if (bub && (e % 2 == 1) && (e != N * N - 1)) begin
        in_vld = 1'b0;
        repeat (3) step();
      end
    end
    in_vld = 1'b0;
    chk("first_vld_latency", out_vld, 1);
  endtask

  task automatic recv(input logic [W-1:0] ev [N], input logic [IW-1:0] ei [N],
                      input bit bp, input bit junk);
    int cyc;
    bit done;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      done = 1'b0;
      while (!done) begin
        out_rdy = bp ? (cyc % 3 == 0) : 1'b1;
        in_vld  = junk && !(i == N - 1 && out_rdy);
        in_dat  = $urandom;
        chk("out_vld", out_vld, 1);
        chk("out_dat", out_dat, ev[i]);
        chk("out_idx", out_idx, ei[i]);
        chk("out_last", out_last, (i == N - 1));
        chk("in_rdy_emit", in_rdy, 0);
        done = out_rdy;
        step();
        cyc++;
      end
    end
    in_vld = 1'b0;
    chk("in_rdy_after_last", in_rdy, 1);
    chk("vld_after_last", out_vld, 0);
  endtask

  task automatic rst_pulse();
    rst    = 1'b1;
    in_vld = 1'b0;
    #1;
    chk("in_rdy_in_rst", in_rdy, 1);
    chk("vld_in_rst", out_vld, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_idx", out_idx, 0);
  endtask

  logic [W-1:0]  d_basic [N] = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd0};
  logic [W-1:0]  e_basic [N] = '{32'd12, 32'd5, 32'd0, 32'hFFFF_FFFD};
  logic [IW-1:0] i_basic [N] = '{2'd2, 2'd0, 2'd3, 2'd1};

  logic [W-1:0]  d_tie [N] = '{32'd7, 32'h8000_0000, 32'd7, 32'h7FFF_FFFF};
  logic [W-1:0]  e_tie [N] = '{32'h7FFF_FFFF, 32'd7, 32'd7, 32'h8000_0000};
  logic [IW-1:0] i_tie [N] = '{2'd3, 2'd0, 2'd2, 2'd1};

  logic [W-1:0]  d_inc [N] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic [W-1:0]  e_inc [N] = '{32'd4, 32'd3, 32'd2, 32'd1};
  logic [IW-1:0] i_inc [N] = '{2'd3, 2'd2, 2'd1, 2'd0};

  initial begin
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_dat  = '0;
    out_rdy = 1'b0;
    step();
    step();
    chk("reset_in_rdy", in_rdy, 1);
    chk("reset_out_vld", out_vld, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_dat", out_dat, 0);
    chk("reset_out_idx", out_idx, 0);
    rst = 1'b0;
    step();
    chk("post_reset_in_rdy", in_rdy, 1);

    // basic sort
    send(d_basic, 1'b0);
    recv(e_basic, i_basic, 1'b0, 1'b0);

    // backpressure, junk input while emitting
    send(d_basic, 1'b0);
    recv(e_basic, i_basic, 1'b1, 1'b1);

    // input bubbles
    send(d_basic, 1'b1);
    recv(e_basic, i_basic, 1'b0, 1'b0);

    // reset after 9 input transfers
    for (int e = 0; e < 9; e++) begin
      in_vld = 1'b1;
      in_dat = 32'd1000 + 32'(e);
      step();
    end
    rst_pulse();
    send(d_inc, 1'b0);
    recv(e_inc, i_inc, 1'b0, 1'b0);

    // reset after the 2nd output handshake
    send(d_basic, 1'b0);
    out_rdy = 1'b1;
    chk("pre_rst_dat0", out_dat, 32'd12);
    step();
    chk("pre_rst_dat1", out_dat, 32'd5);
    step();
    rst_pulse();
    repeat (3) begin
      step();
      chk("no_vld_after_rst", out_vld, 0);
      chk("rdy_after_rst", in_rdy, 1);
    end

    // back-to-back matrices
    send(d_basic, 1'b0);
    recv(e_basic, i_basic, 1'b0, 1'b0);
    send(d_tie, 1'b0);
    recv(e_tie, i_tie, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jacobi_eigval_sorter.md
# jacobi_eigval_sorter

Downstream stage of the Jacobi eigenvalue core. It consumes the diagonalised N×N matrix streamed out of the core in row-major order and keeps only the diagonal elements (the eigenvalues). It emits those eigenvalues sorted in descending signed order, each tagged with its original diagonal index, over a valid/ready stream. Off-diagonal elements are accepted and discarded.

## Interface

Parameters:
- N, default 8: matrix dimension. Legal range is 2..16.
- WIDTH, default 32: data word width. Equals the Jacobi core output word width. Data is signed two's complement fixed point.
- IDX_W, default $clog2(N): width of the eigenvalue index.

Ports:
- clk, input, 1: sole clock. Everything is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- in_dat_i, input, WIDTH: matrix element from the Jacobi core output stream.
- in_vld_i, input, 1: in_dat_i is valid.
- in_rdy_o, output, 1: block accepts input this cycle.
- out_dat_o, output, WIDTH: eigenvalue.
- out_idx_o, output, IDX_W: original diagonal position r of the eigenvalue (element A[r][r]).
- out_last_o, output, 1: marks the final (smallest) eigenvalue of the set.
- out_vld_o, output, 1: output beat is valid.
- out_rdy_i, input, 1: consumer accepts the beat.

## Operation

- **State machine.** Two states, COLLECT and EMIT. Reset enters COLLECT.
- **COLLECT.**
  - in_rdy_o = 1 and out_vld_o = 0.
  - A beat transfers when in_vld_i && in_rdy_o.
  - Counters: row and col, both 0..N-1. col increments on every transfer. When col wraps, row increments.
  - A transfer with row == col is a diagonal element.
- **Insertion sort on diagonal elements.**
  - Sorted register array val[0..N-1] and idx[0..N-1], plus count k of filled entries.
  - Insert position p = number of filled entries whose value is >= the new value (signed compare).
  - Entries p..k-1 shift to p+1..k. The new value and its row go to slot p. k increments.
  - Result: descending order. Ties keep arrival order, so the lower index comes first.
- **Leaving COLLECT.** On transfer of element N*N-1 (row == col == N-1), go to EMIT. Reset row, col, and the read pointer rp to 0.
- **EMIT.**
  - in_rdy_o = 0.
  - out_dat_o = val[rp], out_idx_o = idx[rp], out_last_o = (rp == N-1), out_vld_o = 1.
  - On out_vld_o && out_rdy_i, rp increments.
  - On the handshake with out_last_o = 1, clear k and return to COLLECT.
- **Output stability.** While out_vld_o = 1 and out_rdy_i = 0, out_dat_o, out_idx_o and out_last_o hold stable.
- **No overlap.** A new matrix is never accepted while emitting.
- **Arithmetic.** Compares only. No data width change. 0x80000000 is the most negative value; there is no saturation concern.
- **Reset.** Reset at any point, including mid-COLLECT or mid-EMIT, discards all partial state. k = 0, row = col = rp = 0, state = COLLECT.
- **Reset values of outputs.**
  - in_rdy_o = 1 (state COLLECT). It is asserted on the first cycle after rst deasserts and also during rst.
  - out_vld_o = 0 and out_last_o = 0.
  - out_dat_o = 0 and out_idx_o = 0.

## Timing

- The insertion completes in the same cycle as the diagonal transfer. The array is updated at that clock edge, and the next element may arrive on the following cycle.
- Last input transfer at edge t: out_vld_o = 1 from the cycle after t, presenting the largest eigenvalue. Latency from last input to first output is 1 cycle.
- Throughput is one output per cycle while out_rdy_i = 1. N outputs take a minimum of N cycles.
- Last output handshake at edge u: in_rdy_o = 1 in the cycle after u.
- Minimum period per matrix is N*N + N cycles.
- in_vld_i gaps (bubbles) are allowed anywhere. The counters advance only on transfers.
- out_rdy_i may toggle arbitrarily. rp advances only on handshakes.
- in_dat_i presented while in_rdy_o = 0 is ignored.

## Test plan

- **Basic sort.** N=4, diagonal [5, -3, 12, 0], off-diagonals 0x7FFF_FFFF, continuous valid. Expected (12,2), (5,0), (0,3), (-3,1), with last on (-3,1). First out_vld_o arrives 1 cycle after the 16th transfer.
- **Ties and extremes.** N=4, diagonal [7, 0x8000_0000, 7, 0x7FFF_FFFF]. Expected (0x7FFFFFFF,3), (7,0), (7,2), (0x80000000,1).
- **Backpressure.** Basic-sort stimulus with out_rdy_i toggling 1,0,0,1,... Outputs hold stable while stalled, order is unchanged, and in_rdy_o stays 0 until the last handshake, then rises the next cycle.
- **Input bubbles.** Basic-sort stimulus with in_vld_i deasserted for 3 cycles after every 2nd beat. Result is identical to basic sort.
- **Reset mid-operation.** Assert rst after 9 input transfers, then send a full new matrix with diagonal [1, 2, 3, 4]. Expected (4,3), (3,2), (2,1), (1,0), with no stale values. Repeat with rst asserted after the 2nd output handshake: no further out_vld_o, and in_rdy_o = 1.
- **Back-to-back matrices.** Two consecutive matrices with no idle cycles. The second matrix's first input is accepted the cycle after the first matrix's last output, and both result sets are correct.
